// File: rtl/exp1_tdm_demux14.sv
// 1:4 time-division demultiplexer with frame-sync tracking for a 2-bit TDM stream.
// Optional build macro FRAME_LATCH_EN: F0..F3 update together at frame completion from shadow registers.
//
// state | meaning
// IDLE  | after reset; waiting for the first frame_sync word
// RUN   | aligned; ch tracks the slot of the next valid word
// LOST  | alignment lost (missing sync at slot 0); waiting for frame_sync
module exp1_tdm_demux14 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [1:0] F0,
  output logic [1:0] F1,
  output logic [1:0] F2,
  output logic [1:0] F3,
  output logic [1:0] ch,
  output logic       locked,
  output logic       frame_done,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ch_nxt;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic       done_nxt;
  logic       err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= 2'd0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    wr_en     = 1'b0;
    wr_ch     = 2'd0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      case (state)
        RUN: begin
          if (frame_sync) begin
            // sync at slot 0 is the normal case; anywhere else it is a resync
            wr_en   = 1'b1;
            wr_ch   = 2'd0;
            ch_nxt  = 2'd1;
            err_nxt = (ch != 2'd0);
          end else if (ch == 2'd0) begin
            err_nxt   = 1'b1;
            state_nxt = LOST;
            ch_nxt    = 2'd0;
          end else begin
            wr_en    = 1'b1;
            wr_ch    = ch;
            ch_nxt   = ch + 2'd1;
            done_nxt = (ch == 2'd3);
          end
        end
        IDLE, LOST: begin
          if (frame_sync) begin
            wr_en     = 1'b1;
            wr_ch     = 2'd0;
            ch_nxt    = 2'd1;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
          ch_nxt    = 2'd0;
        end
      endcase
    end
  end

  assign locked = (state == RUN);

`ifdef FRAME_LATCH_EN
  // Slot 3 is only ever written after fresh writes to slots 0..2, so a partial
  // frame in the shadows is always overwritten before it could be published.
  logic [1:0] sh0;
  logic [1:0] sh1;
  logic [1:0] sh2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0 <= 2'd0;
      sh1 <= 2'd0;
      sh2 <= 2'd0;
      F0  <= 2'd0;
      F1  <= 2'd0;
      F2  <= 2'd0;
      F3  <= 2'd0;
    end else if (wr_en) begin
      case (wr_ch)
        2'd0: sh0 <= din;
        2'd1: sh1 <= din;
        2'd2: sh2 <= din;
        default: begin
          F0 <= sh0;
          F1 <= sh1;
          F2 <= sh2;
          F3 <= din;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F0 <= 2'd0;
      F1 <= 2'd0;
      F2 <= 2'd0;
      F3 <= 2'd0;
    end else if (wr_en) begin
      case (wr_ch)
        2'd0:    F0 <= din;
        2'd1:    F1 <= din;
        2'd2:    F2 <= din;
        default: F3 <= din;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_exp1_tdm_demux14.sv
// Directed bench for exp1_tdm_demux14; expected F values follow the FRAME_LATCH_EN build setting.
module tb_exp1_tdm_demux14;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [1:0] F0;
  logic [1:0] F1;
  logic [1:0] F2;
  logic [1:0] F3;
  logic [1:0] ch;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  exp1_tdm_demux14 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .F0(F0), .F1(F1), .F2(F2), .F3(F3), .ch(ch), .locked(locked),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fv(input int a, input int b, input int c, input int d);
    logic [1:0] x0, x1, x2, x3;
    x0 = 2'(a); x1 = 2'(b); x2 = 2'(c); x3 = 2'(d);
    return {x0, x1, x2, x3};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // exp_l applies to the double-buffered build, exp_d to the direct build
  task automatic check_f(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_d);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {F0, F1, F2, F3};
    exp = LATCH ? exp_l : exp_d;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s F0..F3: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input int e_ch, input int e_lock,
                          input int e_done, input int e_err);
    check({tag, " ch"}, int'(ch), e_ch);
    check({tag, " locked"}, int'(locked), e_lock);
    check({tag, " frame_done"}, int'(frame_done), e_done);
    check({tag, " sync_err"}, int'(sync_err), e_err);
  endtask

  task automatic step(input logic v, input logic s, input logic [1:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 2'd0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_f("reset", fv(0,0,0,0), fv(0,0,0,0));
    check_st("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // idle, no sync: discarded
    step(1, 0, 2'd3);
    check_f("idle w1", fv(0,0,0,0), fv(0,0,0,0));
    check_st("idle w1", 0, 0, 0, 0);
    step(1, 0, 2'd3);
    check_f("idle w2", fv(0,0,0,0), fv(0,0,0,0));
    check_st("idle w2", 0, 0, 0, 0);

    // first frame 1,2,3,0
    step(1, 1, 2'd1);
    check_f("fr1 w0", fv(0,0,0,0), fv(1,0,0,0));
    check_st("fr1 w0", 1, 1, 0, 0);
    step(1, 0, 2'd2);
    check_f("fr1 w1", fv(0,0,0,0), fv(1,2,0,0));
    check_st("fr1 w1", 2, 1, 0, 0);
    step(1, 0, 2'd3);
    check_f("fr1 w2", fv(0,0,0,0), fv(1,2,3,0));
    check_st("fr1 w2", 3, 1, 0, 0);
    step(1, 0, 2'd0);
    check_f("fr1 w3", fv(1,2,3,0), fv(1,2,3,0));
    check_st("fr1 w3", 0, 1, 1, 0);
    step(0, 0, 2'd0);
    check_st("fr1 gap", 0, 1, 0, 0);

    // missing sync at slot 0 -> LOST, then reacquire
    step(1, 0, 2'd2);
    check_f("lost", fv(1,2,3,0), fv(1,2,3,0));
    check_st("lost", 0, 0, 0, 1);
    step(1, 1, 2'd1);
    check_f("reacq", fv(1,2,3,0), fv(1,2,3,0));
    check_st("reacq", 1, 1, 0, 0);

    // resync at ch=2
    step(1, 0, 2'd2);
    check_st("pre-resync", 2, 1, 0, 0);
    step(1, 1, 2'd3);
    check_f("resync", fv(1,2,3,0), fv(3,2,3,0));
    check_st("resync", 1, 1, 0, 1);
    step(1, 0, 2'd0);
    check_f("rs w1", fv(1,2,3,0), fv(3,0,3,0));
    check_st("rs w1", 2, 1, 0, 0);
    step(1, 0, 2'd1);
    check_f("rs w2", fv(1,2,3,0), fv(3,0,1,0));
    step(1, 0, 2'd2);
    check_f("rs w3", fv(3,0,1,2), fv(3,0,1,2));
    check_st("rs w3", 0, 1, 1, 0);

    // frame 1,_,2,_,3,_,1 with din_valid gaps
    step(1, 1, 2'd1);
    check_f("gap w0", fv(3,0,1,2), fv(1,0,1,2));
    check_st("gap w0", 1, 1, 0, 0);
    step(0, 1, 2'd3);
    check_f("gap i0", fv(3,0,1,2), fv(1,0,1,2));
    check_st("gap i0", 1, 1, 0, 0);
    step(1, 0, 2'd2);
    check_f("gap w1", fv(3,0,1,2), fv(1,2,1,2));
    step(0, 0, 2'd0);
    check_st("gap i1", 2, 1, 0, 0);
    step(1, 0, 2'd3);
    check_f("gap w2", fv(3,0,1,2), fv(1,2,3,2));
    step(0, 0, 2'd2);
    check_st("gap i2", 3, 1, 0, 0);
    step(1, 0, 2'd1);
    check_f("gap w3", fv(1,2,3,1), fv(1,2,3,1));
    check_st("gap w3", 0, 1, 1, 0);
    step(0, 0, 2'd0);
    check_st("gap post", 0, 1, 0, 0);

    // reset mid-frame
    step(1, 1, 2'd2);
    check_f("mid w0", fv(1,2,3,1), fv(2,2,3,1));
    step(1, 0, 2'd1);
    check_f("mid w1", fv(1,2,3,1), fv(2,1,3,1));
    check_st("mid w1", 2, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_f("async rst", fv(0,0,0,0), fv(0,0,0,0));
    check_st("async rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 2'd3);
    check_f("post rst nosync", fv(0,0,0,0), fv(0,0,0,0));
    check_st("post rst nosync", 0, 0, 0, 0);
    step(1, 1, 2'd2);
    check_f("post rst sync", fv(0,0,0,0), fv(2,0,0,0));
    check_st("post rst sync", 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
